// File: rtl/wino_ctrl_pkg.sv
// Shared types and constants for the Winograd host-side sequencer.
package wino_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ARM   = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } ctrl_state_e;

   localparam logic [1:0] OSM_OFF  = 2'b00;
   localparam logic [1:0] OSM_RUN  = 2'b01;
   localparam logic [1:0] OSM_SCAN = 2'b11;

   // IDLE and DONE behave identically towards start and the core
   function automatic logic is_parked(input ctrl_state_e s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/wino_host_ctrl_if.sv
// Host-facing load and readout streams of the Winograd sequencer.
interface wino_host_ctrl_if #(
   parameter int WORD_W = 512
);
   logic              ld_valid;
   logic              ld_ready;
   logic [WORD_W-1:0] ld_data;
   logic [WORD_W-1:0] ld_weight;
   logic              rd_valid;
   logic              rd_ready;
   logic [WORD_W-1:0] rd_out1;
   logic [WORD_W-1:0] rd_out2;

   modport master (
      output ld_valid, ld_data, ld_weight, rd_ready,
      input  ld_ready, rd_valid, rd_out1, rd_out2
   );

   modport slave (
      input  ld_valid, ld_data, ld_weight, rd_ready,
      output ld_ready, rd_valid, rd_out1, rd_out2
   );
endinterface

// File: rtl/wino_clk_div.sv
// Divide-by-two core clock; upd marks the mem_clk edge on which core_clk falls.
module wino_clk_div (
   input  logic mem_clk,
   input  logic clk_reset,
   output logic core_clk,
   output logic upd
);
   logic core_clk_q;
   logic core_clk_d;

   // next phase of the divided clock
   always_comb begin
      core_clk_d = ~core_clk_q;
   end

   // divider toggle flop
   always_ff @(posedge mem_clk or posedge clk_reset) begin
      if (clk_reset) begin
         core_clk_q <= 1'b0;
      end else begin
         core_clk_q <= core_clk_d;
      end
   end

   assign core_clk = core_clk_q;
   assign upd      = core_clk_q;
endmodule

// File: rtl/wino_host_ctrl.sv
// Load / run / drain sequencer wrapped around the Winograd convolution top.
// Every top-facing output moves only on an update edge (core_clk falling).
module wino_host_ctrl #(
   parameter int DEPTH       = 128,
   parameter int ADDR_W      = 8,
   parameter int WORD_W      = 512,
   parameter int RUN_TIMEOUT = 1024
) (
   input  logic              mem_clk,
   input  logic              clk_reset,
   input  logic              start,
   input  logic [3:0]        cfg_id,
   input  logic [7:0]        cfg_od,
   input  logic [8:0]        cfg_width,
   input  logic [8:0]        cfg_height,
   input  logic              cfg_size_type,
   wino_host_ctrl_if.slave   host,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic              core_clk,
   output logic              core_reset,
   output logic [3:0]        total_id,
   output logic [7:0]        total_od,
   output logic [8:0]        total_width,
   output logic [8:0]        total_height,
   output logic              total_size_type,
   output logic              wen,
   output logic              input_mem_scan_mode,
   output logic [1:0]        output_mem_scan_mode,
   output logic [ADDR_W-1:0] scan_addr,
   output logic [WORD_W-1:0] data_mem_scan_in,
   output logic [WORD_W-1:0] weight_mem_scan_in,
   input  logic [WORD_W-1:0] output_mem1_scan_out,
   input  logic [WORD_W-1:0] output_mem2_scan_out,
   input  logic              conv_completed
);
   import wino_ctrl_pkg::*;

   localparam int                TMR_W     = $clog2(RUN_TIMEOUT) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(RUN_TIMEOUT - 1);

   logic upd_s;

   wino_clk_div u_clk_div (
      .mem_clk   (mem_clk),
      .clk_reset (clk_reset),
      .core_clk  (core_clk),
      .upd       (upd_s)
   );

   ctrl_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              inflight_q, inflight_d;
   logic              all_issued_q, all_issued_d;
   logic              ld_ready_q, ld_ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic [WORD_W-1:0] rd_out1_q, rd_out1_d;
   logic [WORD_W-1:0] rd_out2_q, rd_out2_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_err_q, timeout_err_d;
   logic              core_reset_q, core_reset_d;
   logic              wen_q, wen_d;
   logic              ism_q, ism_d;
   logic [1:0]        osm_q, osm_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic [WORD_W-1:0] data_in_q, data_in_d;
   logic [WORD_W-1:0] weight_in_q, weight_in_d;
   logic [3:0]        total_id_q, total_id_d;
   logic [7:0]        total_od_q, total_od_d;
   logic [8:0]        total_width_q, total_width_d;
   logic [8:0]        total_height_q, total_height_d;
   logic              total_st_q, total_st_d;

   logic rd_take_s;
   logic ld_xfer_s;
   logic space_s;
   logic capture_s;
   logic issue_s;

   // next-state and output computation for the whole sequencer
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rd_cnt_d       = rd_cnt_q;
      timer_d        = timer_q;
      inflight_d     = inflight_q;
      all_issued_d   = all_issued_q;
      rd_valid_d     = rd_valid_q;
      rd_out1_d      = rd_out1_q;
      rd_out2_d      = rd_out2_q;
      busy_d         = busy_q;
      done_d         = done_q;
      timeout_err_d  = timeout_err_q;
      core_reset_d   = core_reset_q;
      wen_d          = wen_q;
      ism_d          = ism_q;
      osm_d          = osm_q;
      scan_addr_d    = scan_addr_q;
      data_in_d      = data_in_q;
      weight_in_d    = weight_in_q;
      total_id_d     = total_id_q;
      total_od_d     = total_od_q;
      total_width_d  = total_width_q;
      total_height_d = total_height_q;
      total_st_d     = total_st_q;
      rd_take_s      = rd_valid_q & host.rd_ready;
      ld_xfer_s      = ld_ready_q & host.ld_valid;
      space_s        = ~rd_valid_q | host.rd_ready;
      capture_s      = 1'b0;
      issue_s        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (upd_s) begin
               core_reset_d = 1'b1;
               wen_d        = 1'b0;
               ism_d        = 1'b0;
               osm_d        = OSM_OFF;
               if (start && is_parked(state_q)) begin
                  state_d        = ST_LOAD;
                  total_id_d     = cfg_id;
                  total_od_d     = cfg_od;
                  total_width_d  = cfg_width;
                  total_height_d = cfg_height;
                  total_st_d     = cfg_size_type;
                  done_d         = 1'b0;
                  timeout_err_d  = 1'b0;
                  busy_d         = 1'b1;
                  cnt_d          = '0;
                  ism_d          = 1'b1;
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            // ld_ready only rises just before an update edge, so a transfer is always on one
            if (ld_xfer_s) begin
               data_in_d   = host.ld_data;
               weight_in_d = host.ld_weight;
               scan_addr_d = cnt_q;
               cnt_d       = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) begin
                  state_d = ST_ARM;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               scan_addr_d = scan_addr_q;
            end
         end
         ST_ARM: begin
            if (upd_s) begin
               ism_d        = 1'b0;
               core_reset_d = 1'b0;
               osm_d        = OSM_RUN;
               wen_d        = 1'b1;
               timer_d      = '0;
               state_d      = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (conv_completed || (timer_q == TMR_LAST)) begin
               state_d       = ST_DRAIN;
               timeout_err_d = ~conv_completed;
               cnt_d         = '0;
               rd_cnt_d      = '0;
               inflight_d    = 1'b0;
               all_issued_d  = 1'b0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_DRAIN: begin
            // one word may sit in top (inflight) and one in the rd register
            capture_s = upd_s & inflight_q & space_s;
            issue_s   = upd_s & ~all_issued_q & (~inflight_q | capture_s);
            if (upd_s) begin
               osm_d = OSM_SCAN;
               wen_d = 1'b0;
            end else begin
               osm_d = osm_q;
            end
            if (capture_s) begin
               rd_out1_d  = output_mem1_scan_out;
               rd_out2_d  = output_mem2_scan_out;
               rd_valid_d = 1'b1;
            end else if (rd_take_s) begin
               rd_valid_d = 1'b0;
            end else begin
               rd_valid_d = rd_valid_q;
            end
            if (issue_s) begin
               scan_addr_d  = cnt_q;
               cnt_d        = cnt_q + ADDR_W'(1);
               inflight_d   = 1'b1;
               all_issued_d = (cnt_q == LAST_ADDR);
            end else if (capture_s) begin
               inflight_d = 1'b0;
            end else begin
               inflight_d = inflight_q;
            end
            if (rd_take_s) begin
               rd_cnt_d = rd_cnt_q + ADDR_W'(1);
               if (rd_cnt_q == LAST_ADDR) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  if (upd_s) begin
                     core_reset_d = 1'b1;
                     osm_d        = OSM_OFF;
                     wen_d        = 1'b0;
                  end else begin
                     core_reset_d = core_reset_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end else begin
               rd_cnt_d = rd_cnt_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ld_ready_d = (state_d == ST_LOAD) & ~upd_s;
   end

   // state and output registers
   always_ff @(posedge mem_clk or posedge clk_reset) begin
      if (clk_reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         rd_cnt_q       <= '0;
         timer_q        <= '0;
         inflight_q     <= 1'b0;
         all_issued_q   <= 1'b0;
         ld_ready_q     <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_out1_q      <= '0;
         rd_out2_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         timeout_err_q  <= 1'b0;
         core_reset_q   <= 1'b1;
         wen_q          <= 1'b0;
         ism_q          <= 1'b0;
         osm_q          <= OSM_OFF;
         scan_addr_q    <= '0;
         data_in_q      <= '0;
         weight_in_q    <= '0;
         total_id_q     <= 4'd0;
         total_od_q     <= 8'd0;
         total_width_q  <= 9'd0;
         total_height_q <= 9'd0;
         total_st_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rd_cnt_q       <= rd_cnt_d;
         timer_q        <= timer_d;
         inflight_q     <= inflight_d;
         all_issued_q   <= all_issued_d;
         ld_ready_q     <= ld_ready_d;
         rd_valid_q     <= rd_valid_d;
         rd_out1_q      <= rd_out1_d;
         rd_out2_q      <= rd_out2_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         timeout_err_q  <= timeout_err_d;
         core_reset_q   <= core_reset_d;
         wen_q          <= wen_d;
         ism_q          <= ism_d;
         osm_q          <= osm_d;
         scan_addr_q    <= scan_addr_d;
         data_in_q      <= data_in_d;
         weight_in_q    <= weight_in_d;
         total_id_q     <= total_id_d;
         total_od_q     <= total_od_d;
         total_width_q  <= total_width_d;
         total_height_q <= total_height_d;
         total_st_q     <= total_st_d;
      end
   end

   assign host.ld_ready        = ld_ready_q;
   assign host.rd_valid        = rd_valid_q;
   assign host.rd_out1         = rd_out1_q;
   assign host.rd_out2         = rd_out2_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign timeout_err          = timeout_err_q;
   assign core_reset           = core_reset_q;
   assign wen                  = wen_q;
   assign input_mem_scan_mode  = ism_q;
   assign output_mem_scan_mode = osm_q;
   assign scan_addr            = scan_addr_q;
   assign data_mem_scan_in     = data_in_q;
   assign weight_mem_scan_in   = weight_in_q;
   assign total_id             = total_id_q;
   assign total_od             = total_od_q;
   assign total_width          = total_width_q;
   assign total_height         = total_height_q;
   assign total_size_type      = total_st_q;
endmodule

// File: tb/tb_wino_host_ctrl.sv
// Directed bench for wino_host_ctrl with a simple address-tagging model of top.
module tb_wino_host_ctrl;
   import wino_ctrl_pkg::*;

   localparam int DEPTH = 128;

   logic         mem_clk = 1'b0;
   logic         clk_reset;
   logic         start;
   logic [3:0]   cfg_id;
   logic [7:0]   cfg_od;
   logic [8:0]   cfg_width;
   logic [8:0]   cfg_height;
   logic         cfg_size_type;
   logic         busy, done, timeout_err, core_clk, core_reset;
   logic [3:0]   total_id;
   logic [7:0]   total_od;
   logic [8:0]   total_width, total_height;
   logic         total_size_type;
   logic         wen, input_mem_scan_mode;
   logic [1:0]   output_mem_scan_mode;
   logic [7:0]   scan_addr;
   logic [511:0] data_mem_scan_in, weight_mem_scan_in;
   logic [511:0] om1 = '0;
   logic [511:0] om2 = '0;
   logic         conv_completed;

   int total = 0;
   int bad   = 0;
   int dcyc;

   wino_host_ctrl_if #(.WORD_W(512)) hif ();

   wino_host_ctrl #(.DEPTH(128), .ADDR_W(8), .WORD_W(512), .RUN_TIMEOUT(1024)) dut (
      .mem_clk              (mem_clk),
      .clk_reset            (clk_reset),
      .start                (start),
      .cfg_id               (cfg_id),
      .cfg_od               (cfg_od),
      .cfg_width            (cfg_width),
      .cfg_height           (cfg_height),
      .cfg_size_type        (cfg_size_type),
      .host                 (hif),
      .busy                 (busy),
      .done                 (done),
      .timeout_err          (timeout_err),
      .core_clk             (core_clk),
      .core_reset           (core_reset),
      .total_id             (total_id),
      .total_od             (total_od),
      .total_width          (total_width),
      .total_height         (total_height),
      .total_size_type      (total_size_type),
      .wen                  (wen),
      .input_mem_scan_mode  (input_mem_scan_mode),
      .output_mem_scan_mode (output_mem_scan_mode),
      .scan_addr            (scan_addr),
      .data_mem_scan_in     (data_mem_scan_in),
      .weight_mem_scan_in   (weight_mem_scan_in),
      .output_mem1_scan_out (om1),
      .output_mem2_scan_out (om2),
      .conv_completed       (conv_completed)
   );

   always #5 mem_clk = ~mem_clk;

   function automatic logic [511:0] dword(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {32{8'h3C, b}};
   endfunction

   function automatic logic [511:0] wword(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {32{8'h7E, b}};
   endfunction

   function automatic logic [511:0] oword1(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {32{8'hC1, b}};
   endfunction

   function automatic logic [511:0] oword2(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {32{8'hD2, b}};
   endfunction

   // output memories of top read the scan address on every core posedge
   always @(posedge core_clk) begin
      om1 <= oword1(int'(scan_addr));
      om2 <= oword2(int'(scan_addr));
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [3:0] id, input logic [7:0] od,
                           input logic [8:0] w, input logic [8:0] h, input logic st);
      cfg_id = id; cfg_od = od; cfg_width = w; cfg_height = h; cfg_size_type = st;
      start = 1'b1;
      @(negedge mem_clk);
      @(negedge mem_clk);
      start = 1'b0;
      chk("start_busy", busy, 1'b1);
      chk("start_done_clr", done, 1'b0);
      chk("start_tmo_clr", timeout_err, 1'b0);
      chk("start_total_id", total_id, id);
      chk("start_total_w", total_width, w);
   endtask

   task automatic load_burst(input int nwords);
      int guard;
      guard = 0;
      while (!hif.ld_ready && guard < 8) begin
         @(negedge mem_clk);
         guard++;
      end
      chk("ld_ready_up", hif.ld_ready, 1'b1);
      chk("ld_ism", input_mem_scan_mode, 1'b1);
      hif.ld_valid = 1'b1;
      for (int k = 0; k < nwords; k++) begin
         hif.ld_data   = dword(k);
         hif.ld_weight = wword(k);
         @(negedge mem_clk);
         chk("ld_addr", scan_addr, k);
         chk("ld_data", data_mem_scan_in, dword(k));
         chk("ld_weight", weight_mem_scan_in, wword(k));
         chk("ld_ready_lo", hif.ld_ready, 1'b0);
         hif.ld_data   = dword(k + 1);
         hif.ld_weight = wword(k + 1);
         @(negedge mem_clk);
         chk("ld_addr_hold", scan_addr, k);
         chk("ld_data_hold", data_mem_scan_in, dword(k));
         chk("ld_ready_next", hif.ld_ready, (k != DEPTH - 1));
      end
      hif.ld_valid = 1'b0;
   endtask

   task automatic drain_all(input logic [6:0] pat, input int max_cyc, output int cycles);
      int n;
      int cyc;
      n   = 0;
      cyc = 0;
      while (n < DEPTH && cyc < max_cyc) begin
         hif.rd_ready = pat[cyc % 7];
         if (hif.rd_valid && hif.rd_ready) begin
            chk("rd_out1", hif.rd_out1, oword1(n));
            chk("rd_out2", hif.rd_out2, oword2(n));
            n++;
         end
         @(negedge mem_clk);
         cyc++;
      end
      hif.rd_ready = 1'b0;
      chk("drain_words", n, DEPTH);
      chk("drain_done", done, 1'b1);
      chk("drain_busy", busy, 1'b0);
      chk("drain_rd_valid", hif.rd_valid, 1'b0);
      @(negedge mem_clk);
      chk("done_core_reset", core_reset, 1'b1);
      chk("done_osm", output_mem_scan_mode, OSM_OFF);
      chk("done_wen", wen, 1'b0);
      cycles = cyc;
   endtask

   initial begin
      int k;
      int cyc;
      logic prev;

      clk_reset = 1'b1; start = 1'b0; conv_completed = 1'b0;
      cfg_id = 4'd0; cfg_od = 8'd0; cfg_width = 9'd0; cfg_height = 9'd0; cfg_size_type = 1'b0;
      hif.ld_valid = 1'b0; hif.ld_data = '0; hif.ld_weight = '0; hif.rd_ready = 1'b0;
      repeat (3) @(negedge mem_clk);
      chk("rst_core_clk", core_clk, 1'b0);
      chk("rst_core_reset", core_reset, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_scan_addr", scan_addr, 8'd0);
      chk("rst_osm", output_mem_scan_mode, OSM_OFF);
      chk("rst_ld_ready", hif.ld_ready, 1'b0);
      clk_reset = 1'b0;
      @(negedge mem_clk);

      // job A: aborted by reset after 37 words
      do_start(4'h3, 8'h21, 9'h1A0, 9'h0F1, 1'b1);
      load_burst(37);
      clk_reset = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_scan_addr", scan_addr, 8'd0);
      chk("abort_data", data_mem_scan_in, 512'd0);
      chk("abort_total_id", total_id, 4'd0);
      chk("abort_core_reset", core_reset, 1'b1);
      chk("abort_ism", input_mem_scan_mode, 1'b0);
      chk("abort_ld_ready", hif.ld_ready, 1'b0);
      chk("abort_core_clk", core_clk, 1'b0);
      @(negedge mem_clk);
      clk_reset = 1'b0;
      @(negedge mem_clk);

      // job B: full load, start ignored in RUN, completion at ~300 cycles
      do_start(4'hA, 8'h5C, 9'h040, 9'h1FF, 1'b0);
      load_burst(DEPTH);
      @(negedge mem_clk);
      chk("arm_wen", wen, 1'b1);
      chk("arm_core_reset", core_reset, 1'b0);
      chk("arm_osm", output_mem_scan_mode, OSM_RUN);
      chk("arm_ism", input_mem_scan_mode, 1'b0);
      cfg_id = 4'h5; cfg_width = 9'h111; start = 1'b1;
      repeat (4) @(negedge mem_clk);
      start = 1'b0;
      chk("run_start_id", total_id, 4'hA);
      chk("run_start_w", total_width, 9'h040);
      chk("run_busy", busy, 1'b1);
      repeat (290) @(negedge mem_clk);
      chk("run_still", output_mem_scan_mode, OSM_RUN);
      conv_completed = 1'b1;
      @(negedge mem_clk);
      conv_completed = 1'b0;
      chk("conv_tmo", timeout_err, 1'b0);
      drain_all(7'b1011001, 3000, dcyc);
      chk("conv_tmo_end", timeout_err, 1'b0);

      // job C from DONE: gapped load, then timeout
      do_start(4'h7, 8'h03, 9'h0AA, 9'h055, 1'b1);
      k = 0; cyc = 0; prev = 1'b0;
      while ((k < DEPTH || prev) && cyc < 1200) begin
         @(negedge mem_clk);
         cyc++;
         if (k > 0) begin
            chk("gap_addr", scan_addr, k - 1);
            chk("gap_data", data_mem_scan_in, dword(k - 1));
         end
         prev = 1'b0;
         if (k < DEPTH) begin
            hif.ld_valid  = ((cyc % 5) < 2);
            hif.ld_data   = dword(k);
            hif.ld_weight = wword(k);
            if (hif.ld_valid && hif.ld_ready) begin
               prev = 1'b1;
               k++;
            end
         end else begin
            hif.ld_valid = 1'b0;
         end
      end
      chk("gap_count", k, DEPTH);
      chk("gap_final_addr", scan_addr, 8'd127);
      @(negedge mem_clk);
      @(negedge mem_clk);
      chk("arm2_wen", wen, 1'b1);
      chk("arm2_osm", output_mem_scan_mode, OSM_RUN);
      repeat (1023) @(negedge mem_clk);
      chk("tmo_pre", timeout_err, 1'b0);
      @(negedge mem_clk);
      chk("tmo_set", timeout_err, 1'b1);
      @(negedge mem_clk);
      chk("drain_osm_wait", output_mem_scan_mode, OSM_RUN);
      @(negedge mem_clk);
      chk("drain_osm", output_mem_scan_mode, OSM_SCAN);
      chk("drain_wen", wen, 1'b0);
      chk("drain_addr0", scan_addr, 8'd0);
      chk("drain_valid_e1", hif.rd_valid, 1'b0);
      @(negedge mem_clk);
      chk("drain_valid_e2", hif.rd_valid, 1'b0);
      @(negedge mem_clk);
      chk("drain_valid_first", hif.rd_valid, 1'b1);
      chk("drain_first_word", hif.rd_out1, oword1(0));
      drain_all(7'b1111111, 600, dcyc);
      chk("drain_rate", dcyc, 255);
      chk("tmo_sticky", timeout_err, 1'b1);

      // job D clears the sticky timeout flag
      do_start(4'h1, 8'h10, 9'h020, 9'h030, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
